// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// fetch_entry_t pairs a fetched instruction word with its byte address.
package fetch_pkg;

  localparam int XLEN    = 32;
  localparam int IMEM_AW = 12;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo2.sv
// Two-entry output buffer for fetched instructions.
// entry0 is always the head, so the head output comes straight from a register.
module fetch_fifo2 import fetch_pkg::*; (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output logic [1:0]   count,
  output fetch_entry_t head
);

  fetch_entry_t entry0;
  fetch_entry_t entry1;
  logic         do_pop;
  logic         do_push;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);
  assign head    = entry0;

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= 2'd0;
      entry0 <= '0;
      entry1 <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (count == 2'd0) entry0 <= push_data;
          else               entry1 <= push_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          entry0 <= entry1;
          count  <= count - 2'd1;
        end
        2'b11: begin
          // Count is unchanged; the pushed entry lands behind whatever remains.
          if (count == 2'd1) begin
            entry0 <= push_data;
          end else begin
            entry0 <= entry1;
            entry1 <= push_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: issues sequential reads to a one-cycle-latency
// instruction RAM and buffers results in a 2-entry FIFO toward decode.
module inst_fetch_unit import fetch_pkg::*; #(
  parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [XLEN-1:0]    imem_rdata,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_pc,
  output logic [XLEN-1:0]    out_instr
);

  localparam logic [2:0] OCC_LIMIT = 3'(FIFO_DEPTH);

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] inflight_pc;
  logic            inflight;
  logic [1:0]      count;
  fetch_entry_t    head;
  fetch_entry_t    push_data;
  logic            fire;
  logic            issue;
  logic            push;
  logic [2:0]      occ_after_fire;

  assign imem_addr = pc[IMEM_AW+1:2];
  assign out_valid = (count != 2'd0);
  assign out_pc    = head.pc;
  assign out_instr = head.instr;
  assign fire      = out_valid && out_ready;

  // Buffered plus in-flight words, counting the slot freed by this cycle's fire.
  assign occ_after_fire = {1'b0, count} + {2'b00, inflight} - {2'b00, fire};
  assign issue          = !redirect_valid && (occ_after_fire < OCC_LIMIT);
  assign push           = inflight && !redirect_valid;
  assign push_data      = '{pc: inflight_pc, instr: imem_rdata};

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect_valid) begin
      pc       <= redirect_pc & ~32'h3;
      inflight <= 1'b0;
    end else if (issue) begin
      pc          <= pc + 32'd4;
      inflight    <= 1'b1;
      inflight_pc <= pc;
    end else begin
      inflight <= 1'b0;
    end
  end

  fetch_fifo2 u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_data),
    .pop       (fire),
    .count     (count),
    .head      (head)
  );

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: in-order scoreboard plus restart timing model,
// and directed scenarios with hand-computed expectations.
module tb_inst_fetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  inst_fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr)
  );

  function automatic logic [31:0] ram_word(input logic [11:0] a);
    return 32'h1000_0000 + {20'h0, a};
  endfunction

  function automatic logic [31:0] instr_at(input logic [31:0] p);
    return ram_word(p[13:2]);
  endfunction

  // RAM preloaded so word k holds 32'h1000_0000 + k; one-cycle read latency.
  always @(posedge clk) imem_rdata <= ram_word(imem_addr);

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic r, input logic rv,
                                input logic [31:0] rpc, input logic rdy);
    @(posedge clk);
    #1;
    rst            = r;
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
  endtask

  // Model: every fire must deliver the next sequential address since the last
  // restart; out_valid is low 2 cycles after a restart, then never drops.
  int          age = 0;
  bit          started = 1'b0;
  logic [31:0] exp_pc = '0;
  logic [31:0] restart_target = '0;
  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic        prev_restart = 1'b1;
  logic [31:0] prev_pc = '0;
  logic [31:0] prev_instr = '0;

  always @(negedge clk) begin
    if (started) begin
      age++;
      if (age >= 1 && age <= 2) check_output("restart_gap_valid", 32'(out_valid), 32'd0);
      else if (age >= 3)        check_output("stream_valid", 32'(out_valid), 32'd1);
      if (age == 1) check_output("restart_imem_addr", 32'(imem_addr), 32'(restart_target[13:2]));
      if (prev_valid && !prev_ready && !prev_restart) begin
        check_output("hold_pc", out_pc, prev_pc);
        check_output("hold_instr", out_instr, prev_instr);
      end
      if (!rst && out_valid && out_ready) begin
        check_output("fire_pc", out_pc, exp_pc);
        check_output("fire_instr", out_instr, instr_at(exp_pc));
        exp_pc = exp_pc + 32'd4;
      end
    end
    if (rst) begin
      started        = 1'b1;
      age            = 0;
      exp_pc         = RST_PC;
      restart_target = RST_PC;
    end else if (redirect_valid) begin
      age            = 0;
      exp_pc         = redirect_pc & ~32'h3;
      restart_target = redirect_pc & ~32'h3;
    end
    prev_valid   = out_valid;
    prev_ready   = out_ready;
    prev_restart = rst || redirect_valid;
    prev_pc      = out_pc;
    prev_instr   = out_instr;
  end

  logic [31:0] held_pc;

  initial begin
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("reset_valid", 32'(out_valid), 32'd0);
    check_output("reset_out_pc", out_pc, 32'h0);
    check_output("reset_out_instr", out_instr, 32'h0);
    check_output("reset_imem_addr", 32'(imem_addr), 32'h0);

    // Reset release and streaming from RESET_PC.
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i < 2) begin
        check_output("startup_gap", 32'(out_valid), 32'd0);
      end else begin
        check_output("startup_valid", 32'(out_valid), 32'd1);
        check_output("startup_pc", out_pc, 32'((i - 2) * 4));
        check_output("startup_instr", out_instr, 32'h1000_0000 + 32'(i - 2));
      end
    end

    // Consumer stall for 5 cycles, then resume.
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    held_pc = out_pc;
    check_output("stall_head_pc", held_pc, 32'h18);
    repeat (4) @(negedge clk);
    check_output("stall_head_stable", out_pc, held_pc);
    check_output("stall_head_instr", out_instr, 32'h1000_0006);
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1);
    repeat (6) @(negedge clk);

    // Redirect with a fire in the same cycle; target is unaligned.
    apply_stimulus(1'b0, 1'b1, 32'h0000_0103, 1'b1);
    @(negedge clk);
    check_output("redir_fire_valid", 32'(out_valid), 32'd1);
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    check_output("redir_gap1", 32'(out_valid), 32'd0);
    @(negedge clk);
    check_output("redir_gap2", 32'(out_valid), 32'd0);
    @(negedge clk);
    check_output("redir_valid", 32'(out_valid), 32'd1);
    check_output("redir_pc", out_pc, 32'h0000_0100);
    check_output("redir_instr", out_instr, 32'h1000_0040);
    repeat (4) @(negedge clk);

    // Back-to-back redirects: the later one wins.
    apply_stimulus(1'b0, 1'b1, 32'h0000_0040, 1'b1);
    apply_stimulus(1'b0, 1'b1, 32'h0000_0080, 1'b1);
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1);
    repeat (2) @(negedge clk);
    @(negedge clk);
    check_output("b2b_valid", 32'(out_valid), 32'd1);
    check_output("b2b_pc", out_pc, 32'h0000_0080);
    check_output("b2b_instr", out_instr, 32'h1000_0020);
    repeat (3) @(negedge clk);

    // Address wrap at the top of the 32-bit space.
    apply_stimulus(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    check_output("wrap_addr0", 32'(imem_addr), 32'h0000_0FFE);
    @(negedge clk);
    check_output("wrap_addr1", 32'(imem_addr), 32'h0000_0FFF);
    @(negedge clk);
    check_output("wrap_addr2", 32'(imem_addr), 32'h0000_0000);
    check_output("wrap_pc0", out_pc, 32'hFFFF_FFF8);
    check_output("wrap_instr0", out_instr, 32'h1000_0FFE);
    @(negedge clk);
    check_output("wrap_pc1", out_pc, 32'hFFFF_FFFC);
    check_output("wrap_instr1", out_instr, 32'h1000_0FFF);
    @(negedge clk);
    check_output("wrap_pc2", out_pc, 32'h0000_0000);
    check_output("wrap_instr2", out_instr, 32'h1000_0000);
    repeat (3) @(negedge clk);

    // Fill the buffer, then reset together with a redirect that must lose.
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0);
    repeat (4) @(negedge clk);
    apply_stimulus(1'b1, 1'b1, 32'h0000_0500, 1'b0);
    apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    check_output("midrst_gap1", 32'(out_valid), 32'd0);
    @(negedge clk);
    check_output("midrst_gap2", 32'(out_valid), 32'd0);
    @(negedge clk);
    check_output("midrst_valid", 32'(out_valid), 32'd1);
    check_output("midrst_pc", out_pc, RST_PC);
    check_output("midrst_instr", out_instr, 32'h1000_0000);
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
